cmat_mul_stream: RTL
====================

# cmat_mul_stream

Parametrised, handshaked complex matrix multiplier computing Y[M×P] = H[M×K] · S[K×P] in fixed-point Q-format. It registers both operand matrices on acceptance. It then streams one output element per cycle through a K-lane complex dot-product pipeline built from the existing `cmult` primitive. It is the successor to the fixed 4×4·4×2 multiplier in the MIMO detection datapath, adding valid/ready flow control, arbitrary dimensions, lane-count independence from M·P, and optional saturation.

## Interface
- Q, 8: fractional bits of every scalar; forwarded to `cmult`.
- N, 16: scalar width (signed).
- M, 4: rows of H and Y.
- K, 4: columns of H, rows of S; equals the cmult lane count.
- P, 2: columns of S and Y.
- CM_LAT, 5: `cmult` latency in cycles; must match the `cmult` build.
- ACCW, N+$clog2(K)+1: dot-product accumulator width.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- h_flat  in  2·M·K·N  H; element (i,k,c) at ((i·K+k)·2+c)·N +: N, c=0 real / 1 imag
- s_flat  in  2·K·P·N  S; element (k,j,c) at ((k·P+j)·2+c)·N +: N
- out_valid  out  1  Y valid
- out_ready  in  1  consumer accepts Y
- y_flat  out  2·M·P·N  Y; element (i,j,c) at ((i·P+j)·2+c)·N +: N
- out_sat  out  1  some element of Y was clipped (see Configuration)

## Operation
- States are IDLE, ISSUE, DRAIN and HOLD.
- **IDLE:** in_ready=1. When in_valid&in_ready is high, the block latches h_flat and s_flat into internal registers, clears e=0 and goes to ISSUE. Inputs need not be held after acceptance.
- **ISSUE:** Each cycle the block drives lane k with H[i][k] and S[k][j], where e = i·P + j in row-major order, then increments e.
  - After e = M·P−1 it goes to DRAIN.
- **cmult handling:** `cmult` instances are free-running; their active-high reset is driven with ~rst_n.
  - A CM_LAT-deep valid shift register tags each issued element with its index.
- **DRAIN:** The block waits until the last tagged element has been written, then goes to HOLD.
- **Per-element pipeline:**
  - Products are sign-extended to ACCW and summed by an adder tree; the sum is registered one cycle.
  - The registered sum is then reduced to N bits and written to the y_flat slot for its index, one cycle.
- **HOLD:** out_valid=1 and y_flat is stable. When out_valid&out_ready is high, the block clears out_valid, sets in_ready and returns to IDLE.
- **Width rule:** accumulation is exact in ACCW bits. Reduction to N bits saturates or wraps per Configuration. No rounding is applied; `cmult` has already scaled by 2^-Q.
- **Reset values (any time):** state=IDLE, e=0, valid tags=0, in_ready=0, out_valid=0, out_sat=0, y_flat=0.
  - in_ready rises on the first clk after rst_n deasserts.
- **Reset mid-operation:** the transaction in flight is discarded. No out_valid is produced for it.
- **Boundary rules:**
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside HOLD.
  - M·P=1 is legal: ISSUE lasts 1 cycle.
  - K=1 is legal: the adder tree is a pass-through.

## Timing
- Acceptance edge = cycle 0. Element e is issued in cycle 1+e.
- Element e's sum is registered at 1+e+CM_LAT, and its y_flat slot is written at 2+e+CM_LAT.
- out_valid rises at L = M·P + CM_LAT + 2. With default parameters L = 15.
- The output handshake occurs on cycle T. in_ready=1 from T+1, so the next acceptance can be at T+1 at the earliest.
- Throughput is one matrix every L+2 cycles, given an immediate out_ready.
- y_flat slots not yet written during ISSUE/DRAIN hold their previous values. Consumers sample only when out_valid=1.

## Configuration
- **CMM_SAT_EN defined:**
  - Each ACCW sum is clamped to [−2^(N−1), 2^(N−1)−1].
  - out_sat is sticky per transaction: it is cleared on acceptance and set if any real or imaginary part clipped. It is valid while out_valid=1.
- **CMM_SAT_EN undefined:**
  - Each sum is truncated to its low N bits (two's-complement wrap).
  - out_sat is tied to 0.

## Structure
- **Package `cmat_pkg`:** state enum `cmm_state_t`, flat-index functions `h_idx`/`s_idx`/`y_idx`, and saturate function `sat_n`.
- **Sub-module `cmat_dot_k`:** K `cmult` instances, the sign-extending adder tree and the sum register.
  - The top level holds the FSM, operand registers, index/tag pipeline and output register.

## Test plan
All scenarios use default parameters (Q=8, so 1.0 = 256).
- **Identity:** H = diag(256+0j), S[k][j] = (k·10+j, −(k·10+j)) → Y == S, out_valid exactly at cycle 15, out_sat=0.
- **All-ones:** H all (256,0), S all (256,256) → every Y = (1024,1024).
- **Imaginary:** H all (0,256), S all (0,256) → every Y = (−1024,0).
- **Overflow:** H all (32767,0), S all (256,0), sum = 131068.
  - With CMM_SAT_EN: Y real = 32767 and out_sat=1.
  - Without: Y real = −4 (0xFFFC) and out_sat=0.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid, then pulse in_valid with new operands.
  - y_flat stays stable, in_ready=0 and the new operands are ignored.
  - After the handshake, in_ready=1 the next cycle and a second transaction returns correct results.
- **Mid-operation reset:** assert rst_n=0 at cycle 5 of ISSUE.
  - All outputs go to 0 asynchronously; no out_valid for that transaction.
  - in_ready=1 one clk after release; a fresh transaction returns correct results.

Source files
------------

// File: rtl/cmat_pkg.sv
// Shared types and helpers for the streaming complex matrix multiplier:
// FSM state encoding, flat-vector element indexing and N-bit saturation.
package cmat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } cmm_state_t;

  // Scalar slot numbers inside the flat operand/result vectors (multiply by N for the bit offset).
  function automatic int h_idx(input int i, input int k, input int c, input int kk);
    return ((i * kk + k) * 2 + c);
  endfunction

  function automatic int s_idx(input int k, input int j, input int c, input int pp);
    return ((k * pp + j) * 2 + c);
  endfunction

  function automatic int y_idx(input int i, input int j, input int c, input int pp);
    return ((i * pp + j) * 2 + c);
  endfunction

  // Clamp a sign-extended value into the signed n-bit range.
  function automatic logic signed [63:0] sat_n(input logic signed [63:0] v, input int n);
    logic signed [63:0] hi_lim;
    logic signed [63:0] lo_lim;
    hi_lim = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo_lim = -(64'sd1 <<< (n - 1));
    if (v > hi_lim) begin
      return hi_lim;
    end else if (v < lo_lim) begin
      return lo_lim;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/cmat_dot_k.sv
// K-lane complex dot product: K cmult lanes, sign-extending adder tree,
// one registered ACCW-bit sum per real/imaginary part.
module cmat_dot_k
  import cmat_pkg::*;
#(
  parameter int Q      = 8,
  parameter int N      = 16,
  parameter int K      = 4,
  parameter int CM_LAT = 5,
  parameter int ACCW   = N + $clog2(K) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [K-1:0][N-1:0]    h_re_i,
  input  logic [K-1:0][N-1:0]    h_im_i,
  input  logic [K-1:0][N-1:0]    s_re_i,
  input  logic [K-1:0][N-1:0]    s_im_i,
  output logic signed [ACCW-1:0] sum_re_o,
  output logic signed [ACCW-1:0] sum_im_o
);

  logic [K-1:0][N:0]      p_re_s;
  logic [K-1:0][N:0]      p_im_s;
  logic signed [ACCW-1:0] acc_re_s;
  logic signed [ACCW-1:0] acc_im_s;
  logic signed [ACCW-1:0] sum_re_q;
  logic signed [ACCW-1:0] sum_im_q;

  for (genvar k = 0; k < K; k++) begin : g_lane
    cmult #(
      .Q   (Q),
      .N   (N),
      .LAT (CM_LAT)
    ) u_cmult (
      .clk_i  (clk_i),
      .rst_i  (~rst_ni),
      .a_re_i (h_re_i[k]),
      .a_im_i (h_im_i[k]),
      .b_re_i (s_re_i[k]),
      .b_im_i (s_im_i[k]),
      .p_re_o (p_re_s[k]),
      .p_im_o (p_im_s[k])
    );
  end

  // Adder tree; ACCW leaves headroom for K full-scale products, so the sum is exact
  always_comb begin
    acc_re_s = {ACCW{1'b0}};
    acc_im_s = {ACCW{1'b0}};
    for (int k = 0; k < K; k++) begin
      acc_re_s = acc_re_s + ACCW'($signed(p_re_s[k]));
      acc_im_s = acc_im_s + ACCW'($signed(p_im_s[k]));
    end
  end

  // Sum register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_re_q <= {ACCW{1'b0}};
      sum_im_q <= {ACCW{1'b0}};
    end else begin
      sum_re_q <= acc_re_s;
      sum_im_q <= acc_im_s;
    end
  end

  assign sum_re_o = sum_re_q;
  assign sum_im_o = sum_im_q;

endmodule

// File: rtl/cmult.sv
// Free-running pipelined complex multiplier: p = a*b scaled by 2^-Q,
// LAT register stages, N+1-bit signed result parts.
module cmult #(
  parameter int Q   = 8,
  parameter int N   = 16,
  parameter int LAT = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic signed [N-1:0] a_re_i,
  input  logic signed [N-1:0] a_im_i,
  input  logic signed [N-1:0] b_re_i,
  input  logic signed [N-1:0] b_im_i,
  output logic signed [N:0]   p_re_o,
  output logic signed [N:0]   p_im_o
);

  localparam int PW = 2 * N + 1;

  logic signed [PW-1:0] re_full_s;
  logic signed [PW-1:0] im_full_s;
  logic signed [PW-1:0] re_sh_s;
  logic signed [PW-1:0] im_sh_s;
  logic signed [N:0]    re_q [LAT];
  logic signed [N:0]    im_q [LAT];

  // Full-precision product, arithmetic shift drops the Q fractional bits
  always_comb begin
    re_full_s = PW'(a_re_i) * PW'(b_re_i) - PW'(a_im_i) * PW'(b_im_i);
    im_full_s = PW'(a_re_i) * PW'(b_im_i) + PW'(a_im_i) * PW'(b_re_i);
    re_sh_s   = re_full_s >>> Q;
    im_sh_s   = im_full_s >>> Q;
  end

  // Latency pipeline
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < LAT; s++) begin
        re_q[s] <= {(N + 1){1'b0}};
        im_q[s] <= {(N + 1){1'b0}};
      end
    end else begin
      re_q[0] <= re_sh_s[N:0];
      im_q[0] <= im_sh_s[N:0];
      for (int s = 1; s < LAT; s++) begin
        re_q[s] <= re_q[s-1];
        im_q[s] <= im_q[s-1];
      end
    end
  end

  assign p_re_o = re_q[LAT-1];
  assign p_im_o = im_q[LAT-1];

endmodule

// File: rtl/cmat_mul_stream.sv
// Handshaked complex matrix multiplier Y = H*S, one output element per cycle.
// Build option CMM_SAT_EN: saturate to N bits and report clipping on out_sat_o; otherwise wrap.
module cmat_mul_stream
  import cmat_pkg::*;
#(
  parameter int Q      = 8,
  parameter int N      = 16,
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int P      = 2,
  parameter int CM_LAT = 5,
  parameter int ACCW   = N + $clog2(K) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [2*M*K*N-1:0] h_flat_i,
  input  logic [2*K*P*N-1:0] s_flat_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*M*P*N-1:0] y_flat_o,
  output logic               out_sat_o
);

  localparam int HW = 2 * M * K * N;
  localparam int SW = 2 * K * P * N;
  localparam int YW = 2 * M * P * N;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (P > 1) ? $clog2(P) : 1;

  cmm_state_t state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;

  logic [HW-1:0] h_q;
  logic [SW-1:0] s_q;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic          done_q;
  logic [YW-1:0] y_q;

  logic [CM_LAT:0]         tag_v_q;
  logic [CM_LAT:0][IW-1:0] tag_i_q;
  logic [CM_LAT:0][JW-1:0] tag_j_q;

  logic accept_s, issue_s, last_s, wr_last_s;

  logic [K-1:0][N-1:0]    h_re_s, h_im_s, s_re_s, s_im_s;
  logic signed [ACCW-1:0] sum_re_s, sum_im_s;
  logic [N-1:0]           red_re_s, red_im_s;

  assign accept_s  = (state_q == IDLE) && in_valid_i && in_ready_q;
  assign issue_s   = (state_q == ISSUE);
  assign last_s    = (i_q == IW'(M - 1)) && (j_q == JW'(P - 1));
  assign wr_last_s = tag_v_q[CM_LAT] && (tag_i_q[CM_LAT] == IW'(M - 1))
                     && (tag_j_q[CM_LAT] == JW'(P - 1));

  // State and registered handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i && in_ready_q) state_d = ISSUE; else state_d = IDLE;
      ISSUE:   if (last_s) state_d = DRAIN; else state_d = ISSUE;
      DRAIN:   if (done_q) state_d = HOLD; else state_d = DRAIN;
      HOLD:    if (out_ready_i && out_valid_q) state_d = IDLE; else state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs follow the state being entered so they are valid right at the edge
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  // Row-major element counter (e = i*P + j)
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (accept_s) begin
      i_d = {IW{1'b0}};
      j_d = {JW{1'b0}};
    end else if (issue_s) begin
      if (j_q == JW'(P - 1)) begin
        j_d = {JW{1'b0}};
        if (i_q == IW'(M - 1)) begin
          i_d = {IW{1'b0}};
        end else begin
          i_d = i_q + IW'(1);
        end
      end else begin
        j_d = j_q + JW'(1);
      end
    end else begin
      i_d = i_q;
      j_d = j_q;
    end
  end

  // Lane operands: row i of H against column j of S
  always_comb begin
    for (int k = 0; k < K; k++) begin
      h_re_s[k] = h_q[h_idx(int'(i_q), k, 0, K) * N +: N];
      h_im_s[k] = h_q[h_idx(int'(i_q), k, 1, K) * N +: N];
      s_re_s[k] = s_q[s_idx(k, int'(j_q), 0, P) * N +: N];
      s_im_s[k] = s_q[s_idx(k, int'(j_q), 1, P) * N +: N];
    end
  end

  cmat_dot_k #(
    .Q      (Q),
    .N      (N),
    .K      (K),
    .CM_LAT (CM_LAT),
    .ACCW   (ACCW)
  ) u_dot (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .h_re_i   (h_re_s),
    .h_im_i   (h_im_s),
    .s_re_i   (s_re_s),
    .s_im_i   (s_im_s),
    .sum_re_o (sum_re_s),
    .sum_im_o (sum_im_s)
  );

`ifdef CMM_SAT_EN
  logic signed [63:0] sat_re_s, sat_im_s;
  logic               clip_s;
  logic               sat_q;

  // Clamp each part to N bits and flag any clipping
  always_comb begin
    sat_re_s = sat_n(64'(sum_re_s), N);
    sat_im_s = sat_n(64'(sum_im_s), N);
    red_re_s = sat_re_s[N-1:0];
    red_im_s = sat_im_s[N-1:0];
    clip_s   = (sat_re_s != 64'(sum_re_s)) || (sat_im_s != 64'(sum_im_s));
  end

  // Sticky clip flag, scoped to one transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_q <= 1'b0;
    end else if (accept_s) begin
      sat_q <= 1'b0;
    end else if (tag_v_q[CM_LAT] && clip_s) begin
      sat_q <= 1'b1;
    end
  end

  assign out_sat_o = sat_q;
`else
  // Two's-complement wrap: keep the low N bits
  always_comb begin
    red_re_s = N'(sum_re_s);
    red_im_s = N'(sum_im_s);
  end

  assign out_sat_o = 1'b0;
`endif

  // Operand capture, counters, index tags and the output slot writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q     <= {HW{1'b0}};
      s_q     <= {SW{1'b0}};
      i_q     <= {IW{1'b0}};
      j_q     <= {JW{1'b0}};
      tag_v_q <= {(CM_LAT + 1){1'b0}};
      tag_i_q <= {((CM_LAT + 1) * IW){1'b0}};
      tag_j_q <= {((CM_LAT + 1) * JW){1'b0}};
      done_q  <= 1'b0;
      y_q     <= {YW{1'b0}};
    end else begin
      if (accept_s) begin
        h_q <= h_flat_i;
        s_q <= s_flat_i;
      end
      i_q <= i_d;
      j_q <= j_d;
      // Tag CM_LAT tracks the sum register; older stages shadow the cmult pipeline
      tag_v_q <= {tag_v_q[CM_LAT-1:0], issue_s};
      tag_i_q <= {tag_i_q[CM_LAT-1:0], i_q};
      tag_j_q <= {tag_j_q[CM_LAT-1:0], j_q};
      if (tag_v_q[CM_LAT]) begin
        y_q[y_idx(int'(tag_i_q[CM_LAT]), int'(tag_j_q[CM_LAT]), 0, P) * N +: N] <= red_re_s;
        y_q[y_idx(int'(tag_i_q[CM_LAT]), int'(tag_j_q[CM_LAT]), 1, P) * N +: N] <= red_im_s;
      end
      if (accept_s) begin
        done_q <= 1'b0;
      end else if (wr_last_s) begin
        done_q <= 1'b1;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign y_flat_o    = y_q;

endmodule
